// File: rtl/shift_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_ex_stage
// Brief    : Execute-stage sequencer for R-type shifts; registers a decoded op,
//            drives the external 32-bit shifter and holds the result for writeback.
// Revision : 1.0 - initial release
// ============================================================================
module shift_ex_stage #(
  parameter int RD_W    = 5,
  parameter bit R0_NOWE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_funct,
  input  logic [4:0]      in_shamt,
  input  logic [31:0]     in_rs,
  input  logic [31:0]     in_rt,
  input  logic [RD_W-1:0] in_rd,
  output logic [31:0]     sh_a,
  output logic [4:0]      sh_amt,
  output logic            sh_ext,
  input  logic [31:0]     sh_y,
  input  logic [31:0]     sh_z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  localparam logic [5:0] c_FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] c_FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] c_FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] c_FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] c_FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] c_FUNCT_SRAV = 6'b000111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;

  logic [31:0]     op_data_q;
  logic [4:0]      op_amt_q;
  logic            op_ext_q;
  logic            op_left_q;
  logic            op_legal_q;
  logic [RD_W-1:0] op_rd_q;

  logic [4:0]      dec_amt_d;
  logic            dec_ext_d;
  logic            dec_left_d;
  logic            dec_legal_d;

  logic            out_valid_q;
  logic [31:0]     out_result_q;
  logic [RD_W-1:0] out_rd_q;
  logic            out_we_q;
  logic            out_illegal_q;

  logic            w_load;
  logic [31:0]     w_result;
  logic            w_we;
  logic            w_rs_unused;

  // Upper rs bits never matter: variable shifts use only the low five.
  assign w_rs_unused = ^in_rs[31:5];

  always_comb begin
    dec_amt_d   = in_shamt;
    dec_ext_d   = 1'b0;
    dec_left_d  = 1'b0;
    dec_legal_d = 1'b1;
    unique case (in_funct)
      c_FUNCT_SLL:  dec_left_d = 1'b1;
      c_FUNCT_SRL:  dec_ext_d  = 1'b0;
      c_FUNCT_SRA:  dec_ext_d  = 1'b1;
      c_FUNCT_SLLV: begin
        dec_amt_d  = in_rs[4:0];
        dec_left_d = 1'b1;
      end
      c_FUNCT_SRLV: dec_amt_d = in_rs[4:0];
      c_FUNCT_SRAV: begin
        dec_amt_d = in_rs[4:0];
        dec_ext_d = 1'b1;
      end
      default: begin
        dec_amt_d   = 5'd0;
        dec_legal_d = 1'b0;
      end
    endcase
  end

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign w_load   = in_valid && in_ready;

  assign w_result = !op_legal_q ? 32'd0 : (op_left_q ? sh_z : sh_y);
  assign w_we     = op_legal_q && !(R0_NOWE && (op_rd_q == '0));

  // Shifter inputs are quiet while idle and keep the last op afterwards.
  assign sh_a   = (state_q == IDLE) ? 32'd0 : op_data_q;
  assign sh_amt = (state_q == IDLE) ? 5'd0  : op_amt_q;
  assign sh_ext = (state_q == IDLE) ? 1'b0  : op_ext_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_data_q     <= 32'd0;
      op_amt_q      <= 5'd0;
      op_ext_q      <= 1'b0;
      op_left_q     <= 1'b0;
      op_legal_q    <= 1'b0;
      op_rd_q       <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= 32'd0;
      out_rd_q      <= '0;
      out_we_q      <= 1'b0;
      out_illegal_q <= 1'b0;
    end else if (flush) begin
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      out_we_q      <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      if (w_load) begin
        op_data_q  <= in_rt;
        op_amt_q   <= dec_amt_d;
        op_ext_q   <= dec_ext_d;
        op_left_q  <= dec_left_d;
        op_legal_q <= dec_legal_d;
        op_rd_q    <= in_rd;
      end
      unique case (state_q)
        IDLE: begin
          if (in_valid) state_q <= BUSY;
        end
        BUSY: begin
          out_valid_q   <= 1'b1;
          out_result_q  <= w_result;
          out_rd_q      <= op_rd_q;
          out_we_q      <= w_we;
          out_illegal_q <= !op_legal_q;
          state_q       <= DONE;
        end
        DONE: begin
          // A consumed result frees the stage; a waiting op hands off directly.
          if (out_ready) begin
            out_valid_q   <= 1'b0;
            out_we_q      <= 1'b0;
            out_illegal_q <= 1'b0;
            state_q       <= in_valid ? BUSY : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_we      = out_we_q;
  assign out_illegal = out_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_ex_stage
// Brief    : Scoreboard bench for shift_ex_stage with a behavioural shift model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_ex_stage;

  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, in_ready;
  logic [5:0]      in_funct;
  logic [4:0]      in_shamt;
  logic [31:0]     in_rs, in_rt;
  logic [RD_W-1:0] in_rd;
  logic [31:0]     sh_a, sh_y, sh_z;
  logic [4:0]      sh_amt;
  logic            sh_ext;
  logic            out_valid, out_ready, out_we, out_illegal;
  logic [31:0]     out_result;
  logic [RD_W-1:0] out_rd;

  typedef struct {
    logic [31:0]     res;
    logic [RD_W-1:0] rd;
    logic            we;
    logic            ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random

  shift_ex_stage #(.RD_W(RD_W), .R0_NOWE(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .sh_a(sh_a), .sh_amt(sh_amt), .sh_ext(sh_ext), .sh_y(sh_y), .sh_z(sh_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Combinational shifter the stage drives.
  assign sh_y = sh_ext ? 32'($signed(sh_a) >>> sh_amt) : (sh_a >> sh_amt);
  assign sh_z = sh_a << sh_amt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [RD_W-1:0] rd);
    exp_t e;
    logic legal = 1'b1;
    e.rd  = rd;
    e.res = 32'd0;
    case (f)
      6'b000000: e.res = rt << sh;
      6'b000010: e.res = rt >> sh;
      6'b000011: e.res = 32'($signed(rt) >>> sh);
      6'b000100: e.res = rt << rs[4:0];
      6'b000110: e.res = rt >> rs[4:0];
      6'b000111: e.res = 32'($signed(rt) >>> rs[4:0]);
      default:   legal = 1'b0;
    endcase
    e.ill = !legal;
    e.we  = legal && (rd != 0);
    return e;
  endfunction

  task automatic issue(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [RD_W-1:0] rd,
                       input bit use_c, input logic [31:0] c_res);
    exp_t e;
    bit   acc = 1'b0;
    in_valid = 1'b1; in_funct = f; in_shamt = sh; in_rs = rs; in_rt = rt; in_rd = rd;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready && !flush && !reset) begin
        e = model(f, sh, rs, rt, rd);
        if (use_c) e.res = c_res;
        sb.push_back(e);
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_out_valid();
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_we", 32'(out_we), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_sh_a", sh_a, 32'd0);
    chk("rst_sh_amt", 32'(sh_amt), 32'd0);
  endtask

  // Writeback-side ready driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
      else               out_ready = (rdy_mode == 0);
    end
  end

  // Monitor: timing expectations from the handshake rules, results from the scoreboard.
  initial begin : monitor
    bit          pend      = 1'b0;
    int          age       = 0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_res  = 32'd0;
    bit          exp_valid;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0; prev_hold = 1'b0;
        continue;
      end
      if (pend) age++;
      exp_valid = pend && (age >= 2);
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("in_ready", 32'(in_ready), 32'(!pend || (exp_valid && out_ready)));
      if (!pend) begin
        chk("idle_sh_a", sh_a, 32'd0);
        chk("idle_sh_ext", 32'(sh_ext), 32'd0);
      end
      if (prev_hold) chk("hold_stable", out_result, prev_res);
      if (flush) begin
        pend = 1'b0; prev_hold = 1'b0;
      end else begin
        if (exp_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            chk("result", out_result, e.res);
            chk("rd", 32'(out_rd), 32'(e.rd));
            chk("we", 32'(out_we), 32'(e.we));
            chk("illegal", 32'(out_illegal), 32'(e.ill));
          end
          pend = 1'b0;
        end
        if (in_valid && (!pend || (exp_valid && out_ready)) && in_ready) begin
          pend = 1'b1; age = 0;
        end
        prev_hold = exp_valid && !out_ready;
        prev_res  = out_result;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal_f [6];
    logic [5:0] f;
    int         pick;
    legal_f[0] = 6'b000000; legal_f[1] = 6'b000010; legal_f[2] = 6'b000011;
    legal_f[3] = 6'b000100; legal_f[4] = 6'b000110; legal_f[5] = 6'b000111;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_funct = 6'd0; in_shamt = 5'd0;
    in_rs = 32'd0; in_rt = 32'd0; in_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed value cases
    rdy_mode = 0;
    issue(6'b000011, 5'd4, 32'd0, 32'h8000_0000, 5'd7, 1'b1, 32'hF800_0000);
    issue(6'b000110, 5'd9, 32'h0000_0023, 32'h0000_00F0, 5'd3, 1'b1, 32'h0000_001E);
    issue(6'b000100, 5'd0, 32'h0000_001F, 32'h0000_0001, 5'd4, 1'b1, 32'h8000_0000);
    issue(6'b000011, 5'd0, 32'd0, 32'h8000_0001, 5'd5, 1'b1, 32'h8000_0001);
    issue(6'b000000, 5'd1, 32'd0, 32'h0000_0001, 5'd0, 1'b1, 32'h0000_0002);
    issue(6'b100000, 5'd3, 32'h5, 32'h1234_5678, 5'd9, 1'b1, 32'h0000_0000);
    repeat (4) @(posedge clk); #1;

    // Backpressure with a second op waiting
    rdy_mode = 1;
    issue(6'b000010, 5'd8, 32'd0, 32'hABCD_0000, 5'd10, 1'b1, 32'h00AB_CD00);
    fork
      issue(6'b000000, 5'd4, 32'd0, 32'h0000_0F0F, 5'd11, 1'b1, 32'h0000_F0F0);
      begin
        repeat (7) @(posedge clk); #1;
        rdy_mode = 0;
      end
    join
    repeat (4) @(posedge clk); #1;

    // Flush while busy, then while holding a result
    rdy_mode = 0;
    issue(6'b000000, 5'd2, 32'd0, 32'h1, 5'd12, 1'b0, 32'd0);
    do_flush();
    issue(6'b000010, 5'd1, 32'd0, 32'h8, 5'd13, 1'b1, 32'h4);
    repeat (3) @(posedge clk); #1;
    rdy_mode = 1;
    issue(6'b000111, 5'd0, 32'h2, 32'hF000_0000, 5'd14, 1'b1, 32'hFC00_0000);
    wait_out_valid();
    do_flush();
    rdy_mode = 0;
    issue(6'b000100, 5'd0, 32'h3, 32'h3, 5'd15, 1'b1, 32'h18);
    repeat (3) @(posedge clk); #1;

    // Reset while holding a result
    rdy_mode = 1;
    issue(6'b000011, 5'd1, 32'd0, 32'h4, 5'd16, 1'b0, 32'd0);
    wait_out_valid();
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    reset = 1'b0;

    // Randomized traffic
    rdy_mode = 2;
    for (int i = 0; i < 250; i++) begin
      pick = $urandom_range(0, 7);
      if (pick == 6) f = 6'b100000 | 6'($urandom_range(0, 31));
      else           f = legal_f[$urandom_range(0, 5)];
      issue(f, 5'($urandom_range(0, 31)), $urandom, $urandom,
            RD_W'($urandom_range(0, 31)), 1'b0, 32'd0);
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        do_flush();
      end else if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    rdy_mode = 0;
    repeat (6) @(posedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
